// File: rtl/shuffle_s_mem_by_key.sv
// ---------------------------------------------------------------------------
// shuffle_s_mem_by_key
//   RC4 key-scheduling shuffle. Runs after the S-memory identity fill and,
//   for i = 0..255, computes j = j + s[i] + key[i mod KEY_BYTES] and swaps
//   s[i] with s[j] through a single-port 256x8 synchronous-read memory.
//   Six cycles per i; all outputs are registered.
//
// Ports
//   clk               in   system clock, posedge
//   reset             in   synchronous active-high reset
//   start             in   begin shuffle (sampled in IDLE only)
//   secret_key        in   key, byte 0 = MSB byte, latched on accepted start
//   mem_data_in       in   S memory read data (valid one cycle after address)
//   address_out       out  S memory address
//   data_out          out  S memory write data
//   write_enable_out  out  S memory write enable
//   shuffle_done      out  high once all 256 swaps are written, until reset
// ---------------------------------------------------------------------------
module shuffle_s_mem_by_key #(
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [KEY_BYTES*8-1:0]  secret_key,
    input  logic [7:0]              mem_data_in,
    output logic [7:0]              address_out,
    output logic [7:0]              data_out,
    output logic                    write_enable_out,
    output logic                    shuffle_done
);

    localparam int unsigned KEY_W = KEY_BYTES * 8;
    localparam int unsigned KW    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ_SI  = 3'd1,
        WAIT_SI  = 3'd2,
        READ_SJ  = 3'd3,
        WAIT_SJ  = 3'd4,
        WRITE_SI = 3'd5,
        WRITE_SJ = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t            r_state;
    logic [KEY_W-1:0]  r_key;
    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [7:0]        r_si;
    logic [KW-1:0]     r_k;

    logic [7:0]        w_key_byte;
    logic [7:0]        w_j_next;

    // Key byte select as a mux over k; byte 0 is the most significant byte.
    always_comb begin
        w_key_byte = 8'h00;
        for (int unsigned b = 0; b < KEY_BYTES; b++) begin
            if (r_k == KW'(b)) begin
                w_key_byte = r_key[(KEY_BYTES-1-b)*8 +: 8];
            end
        end
    end

    // New j from s[i] arriving this cycle; wraps mod 256 by truncation.
    assign w_j_next = r_j + mem_data_in + w_key_byte;

    // Shuffle FSM. Outputs are loaded on the transition into a state so that
    // they hold the required value throughout that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_key            <= '0;
            r_i              <= 8'h00;
            r_j              <= 8'h00;
            r_si             <= 8'h00;
            r_k              <= '0;
            address_out      <= 8'h00;
            data_out         <= 8'h00;
            write_enable_out <= 1'b0;
            shuffle_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    write_enable_out <= 1'b0;
                    if (start) begin
                        r_key       <= secret_key;
                        r_i         <= 8'h00;
                        r_j         <= 8'h00;
                        r_k         <= '0;
                        address_out <= 8'h00;
                        r_state     <= READ_SI;
                    end
                end
                READ_SI: begin
                    r_state <= WAIT_SI;
                end
                WAIT_SI: begin
                    r_si        <= mem_data_in;
                    r_j         <= w_j_next;
                    address_out <= w_j_next;
                    r_state     <= READ_SJ;
                end
                READ_SJ: begin
                    r_state <= WAIT_SJ;
                end
                WAIT_SJ: begin
                    // s[j] goes straight to the write-data register for s[i].
                    address_out      <= r_i;
                    data_out         <= mem_data_in;
                    write_enable_out <= 1'b1;
                    r_state          <= WRITE_SI;
                end
                WRITE_SI: begin
                    address_out      <= r_j;
                    data_out         <= r_si;
                    write_enable_out <= 1'b1;
                    r_state          <= WRITE_SJ;
                end
                WRITE_SJ: begin
                    write_enable_out <= 1'b0;
                    if (r_i == 8'hFF) begin
                        shuffle_done <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_i         <= r_i + 8'd1;
                        address_out <= r_i + 8'd1;
                        r_k         <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
                        r_state     <= READ_SI;
                    end
                end
                DONE: begin
                    write_enable_out <= 1'b0;
                    shuffle_done     <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shuffle_s_mem_by_key.sv
// ---------------------------------------------------------------------------
// tb_shuffle_s_mem_by_key
//   Directed bench for the RC4 KSA shuffle stage with a behavioural
//   single-port synchronous-read S memory and a KSA reference model.
// ---------------------------------------------------------------------------
module tb_shuffle_s_mem_by_key;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  mem_q;
    logic [7:0]  address_out;
    logic [7:0]  data_out;
    logic        write_enable_out;
    logic        shuffle_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shuffle_s_mem_by_key #(.KEY_BYTES(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .secret_key       (secret_key),
        .mem_data_in      (mem_q),
        .address_out      (address_out),
        .data_out         (data_out),
        .write_enable_out (write_enable_out),
        .shuffle_done     (shuffle_done)
    );

    // S memory: read-first synchronous RAM plus a write log.
    logic [7:0] mem [256];
    logic       tb_fill = 1'b0;
    logic       tb_clr  = 1'b0;
    int         wr_cnt  = 0;
    logic [7:0] wr_addr [1024];
    logic [7:0] wr_data [1024];

    always @(posedge clk) begin
        mem_q <= mem[address_out];
        if (tb_clr) wr_cnt = 0;
        if (tb_fill) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (write_enable_out) begin
            mem[address_out] <= data_out;
            if (wr_cnt < 1024) begin
                wr_addr[wr_cnt] = address_out;
                wr_data[wr_cnt] = data_out;
            end
            wr_cnt++;
        end
    end

    logic [7:0] ref_s [256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // C-style RC4 KSA on an identity array.
    task automatic compute_ref(input logic [23:0] key);
        logic [7:0] kb [3];
        logic [7:0] j;
        logic [7:0] t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int i = 0; i < 256; i++) ref_s[i] = 8'(i);
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            j = j + ref_s[i] + kb[i % 3];
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    // Identity-fill memory and clear the write log while the DUT is idle.
    task automatic prep();
        @(negedge clk);
        tb_fill = 1'b1;
        tb_clr  = 1'b1;
        @(negedge clk);
        tb_fill = 1'b0;
        tb_clr  = 1'b0;
    endtask

    // Start a pass and count cycles from leaving IDLE to shuffle_done.
    task automatic run_shuffle(input logic [23:0] key, input bit poke, output int cycles);
        @(negedge clk);
        secret_key = key;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        secret_key = ~key;
        cycles = 0;
        while (cycles < 3000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = poke && (cycles == 300);
            if (shuffle_done) break;
        end
        start = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 256; a++) begin
            check_eq($sformatf("%s s[%0d]", tag, a), 32'(mem[a]), 32'(ref_s[a]));
        end
    endtask

    initial begin
        int cyc;

        // 1: reset with start held high
        reset      = 1'b1;
        start      = 1'b1;
        secret_key = 24'hABCDEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst addr", 32'(address_out), 32'h0);
        check_eq("rst data", 32'(data_out), 32'h0);
        check_eq("rst we", 32'(write_enable_out), 32'h0);
        check_eq("rst done", 32'(shuffle_done), 32'h0);
        reset = 1'b0;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("post-rst idle we", 32'(write_enable_out), 32'h0);
        check_eq("post-rst idle done", 32'(shuffle_done), 32'h0);

        // 2: key 010000
        prep();
        run_shuffle(24'h010000, 1'b0, cyc);
        check_eq("k010000 latency", 32'(cyc), 32'd1536);
        check_eq("k010000 w0 addr", 32'(wr_addr[0]), 32'd0);
        check_eq("k010000 w0 data", 32'(wr_data[0]), 32'd1);
        check_eq("k010000 w1 addr", 32'(wr_addr[1]), 32'd1);
        check_eq("k010000 w1 data", 32'(wr_data[1]), 32'd0);
        check_eq("k010000 i1 j", 32'(wr_addr[3]), 32'd1);
        check_eq("k010000 i1 data", 32'(wr_data[3]), 32'd0);

        // 3: key 000000
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prep();
        run_shuffle(24'h000000, 1'b0, cyc);
        check_eq("k0 w0 addr", 32'(wr_addr[0]), 32'd0);
        check_eq("k0 w1 addr", 32'(wr_addr[1]), 32'd0);
        check_eq("k0 w3 addr", 32'(wr_addr[3]), 32'd1);
        check_eq("k0 w4 addr", 32'(wr_addr[4]), 32'd2);
        check_eq("k0 w4 data", 32'(wr_data[4]), 32'd3);
        check_eq("k0 w5 addr", 32'(wr_addr[5]), 32'd3);
        check_eq("k0 w5 data", 32'(wr_data[5]), 32'd2);

        // 4 + 6: key 000249, start poked mid-run, full content vs reference
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prep();
        compute_ref(24'h000249);
        run_shuffle(24'h000249, 1'b1, cyc);
        check_eq("k249 latency", 32'(cyc), 32'd1536);
        check_eq("k249 we count", 32'(wr_cnt), 32'd512);
        check_mem("k249");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("after-done we count", 32'(wr_cnt), 32'd512);
        check_eq("after-done done", 32'(shuffle_done), 32'h1);
        check_eq("after-done we", 32'(write_enable_out), 32'h0);

        // 5: reset at the edge entering WRITE_SI of i=100
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prep();
        @(negedge clk);
        secret_key = 24'h000249;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (603) @(posedge clk);
        @(negedge clk);
        check_eq("mid pre-rst writes", 32'(wr_cnt), 32'd200);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid rst we", 32'(write_enable_out), 32'h0);
        check_eq("mid rst addr", 32'(address_out), 32'h0);
        check_eq("mid rst data", 32'(data_out), 32'h0);
        check_eq("mid rst done", 32'(shuffle_done), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("mid post-rst writes", 32'(wr_cnt), 32'd200);
        check_eq("mid post-rst done", 32'(shuffle_done), 32'h0);
        prep();
        run_shuffle(24'h000249, 1'b0, cyc);
        check_eq("rerun latency", 32'(cyc), 32'd1536);
        check_eq("rerun we count", 32'(wr_cnt), 32'd512);
        check_mem("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
